// File: rtl/mem_pkg.sv
// Shared definitions for the block-chain memory reader: sizes, the footer
// layout carried in the low 16 bits of every block, and the reader FSM states.
package mem_pkg;

  localparam int ADDR_W     = 12;
  localparam int BLOCK_BITS = 512;
  localparam int FOOTER_W   = 16;
  localparam int MEM_DEPTH  = 1 << ADDR_W;

  // Footer in block bits [15:0]: next_idx=[15:4], eop=[3], rsvd=[2:0].
  typedef struct packed {
    logic [ADDR_W-1:0] next_idx;
    logic              eop;
    logic [2:0]        rsvd;
  } footer_t;

  // Reader FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } rd_state_t;

  // Extracts the footer from a full block.
  function automatic footer_t get_footer(input logic [BLOCK_BITS-1:0] blk);
    return footer_t'(blk[FOOTER_W-1:0]);
  endfunction

  // Builds a footer word; reserved bits are left at zero.
  function automatic logic [FOOTER_W-1:0] make_footer(input logic [ADDR_W-1:0] next_idx,
                                                      input logic              eop);
    footer_t f;
    f.next_idx = next_idx;
    f.eop      = eop;
    f.rsvd     = 3'b000;
    return f;
  endfunction

endpackage

// File: rtl/sram.sv
// Single-port block memory: 2^ADDR_W blocks of BLOCK_BITS. Writes are
// synchronous; read data appears on rdata one cycle after re and holds
// until the next read.
module sram
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [BLOCK_BITS-1:0] wdata,
  output logic [BLOCK_BITS-1:0] rdata
);

  logic [BLOCK_BITS-1:0] mem [MEM_DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read: one cycle of latency, output held between reads.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/memory_read_ctrl.sv
// Linked-block walker. A start pulse gives the first block index; each
// returned block's footer names the next block, and the walk ends on the
// block whose footer has eop set. Every returned block is forwarded on
// data_o with a one-cycle data_valid_o pulse.
//
// Handshake: mem_re_o is a one-cycle request strobe with the address on
// mem_raddr_o; the memory answers with mem_rvalid_i exactly one cycle later.
// Only one read is ever in flight, so no tags or queues are needed. re_i
// gates issue only; a read already in flight always completes.
module memory_read_ctrl
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re_i,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_addr_i,
  output logic                  mem_re_o,
  output logic [ADDR_W-1:0]     mem_raddr_o,
  input  logic                  mem_rvalid_i,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i,
  output logic [BLOCK_BITS-1:0] data_o,
  output logic                  data_valid_o,
  output logic                  data_end_o,
  output rd_state_t             state_o
);

  rd_state_t         state_q;
  rd_state_t         state_d;
  logic [ADDR_W-1:0] cur_addr;
  logic              latch_start;
  logic              deliver;
  footer_t           footer;
  logic              rsvd_unused;

  // Footer of whatever the memory is presenting; only acted on when delivering.
  assign footer      = get_footer(mem_rdata_i);
  assign rsvd_unused = ^footer.rsvd;

  assign mem_raddr_o = cur_addr;
  assign state_o     = state_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; start outside IDLE is deliberately ignored.
  always_comb begin
    state_d     = state_q;
    mem_re_o    = 1'b0;
    latch_start = 1'b0;
    deliver     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch_start = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (re_i) begin
          mem_re_o = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          deliver = 1'b1;
          state_d = footer.eop ? IDLE : ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Current block index: loaded from start, then follows the footer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr <= '0;
    end else if (latch_start) begin
      cur_addr <= start_addr_i;
    end else if (deliver && !footer.eop) begin
      cur_addr <= footer.next_idx;
    end
  end

  // Output register: data held between deliveries, valid/end are pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o       <= '0;
      data_valid_o <= 1'b0;
      data_end_o   <= 1'b0;
    end else begin
      data_valid_o <= deliver;
      data_end_o   <= deliver & footer.eop;
      if (deliver) begin
        data_o <= mem_rdata_i;
      end
    end
  end

  // A strobe must always be followed by the wait state, never by another strobe.
  a_single_outstanding: assert property (@(posedge clk) disable iff (rst)
    mem_re_o |=> (!mem_re_o && state_q == WAIT));

  // Delivery pulses only ever come out one at a time.
  a_valid_pulse: assert property (@(posedge clk) disable iff (rst)
    data_valid_o |=> !data_valid_o);

endmodule

// File: tb/tb_memory_read_ctrl.sv
// Bench for memory_read_ctrl: an sram model backs the reader, a negedge
// monitor scores reads and deliveries against expected queues, and a table
// of walks drives the main test, followed by the reset/late-valid sequence.
module tb_memory_read_ctrl;
  import mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                  re_i;
  logic                  start;
  logic [ADDR_W-1:0]     start_addr_i;
  logic                  mem_re_o;
  logic [ADDR_W-1:0]     mem_raddr_o;
  logic                  mem_rvalid_i;
  logic [BLOCK_BITS-1:0] mem_rdata_i;
  logic [BLOCK_BITS-1:0] data_o;
  logic                  data_valid_o;
  logic                  data_end_o;
  rd_state_t             state_o;

  // memory side
  logic                  we_tb;
  logic [ADDR_W-1:0]     waddr_tb;
  logic [BLOCK_BITS-1:0] wdata_tb;
  logic [ADDR_W-1:0]     sram_addr;
  logic                  rvalid_q = 1'b0;
  logic                  rvalid_force;

  memory_read_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .re_i         (re_i),
    .start        (start),
    .start_addr_i (start_addr_i),
    .mem_re_o     (mem_re_o),
    .mem_raddr_o  (mem_raddr_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_end_o   (data_end_o),
    .state_o      (state_o)
  );

  assign sram_addr = we_tb ? waddr_tb : mem_raddr_o;

  sram u_mem (
    .clk   (clk),
    .we    (we_tb),
    .re    (mem_re_o),
    .addr  (sram_addr),
    .wdata (wdata_tb),
    .rdata (mem_rdata_i)
  );

  // Memory answers exactly one cycle after the strobe.
  always @(posedge clk) rvalid_q <= mem_re_o;
  assign mem_rvalid_i = rvalid_q | rvalid_force;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int dv_cnt = 0;
  bit mon_en = 1'b0;
  logic [ADDR_W-1:0]     exp_addr_q[$];
  logic [BLOCK_BITS-1:0] exp_q[$];
  logic                  exp_end_q[$];
  logic [BLOCK_BITS-1:0] last_exp;

  // bench-side chain model
  logic [ADDR_W-1:0] next_m [MEM_DEPTH];
  logic              eop_m  [MEM_DEPTH];
  logic [ADDR_W-1:0] chain  [10];

  task automatic check(input string name, input logic [BLOCK_BITS-1:0] act,
                       input logic [BLOCK_BITS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [BLOCK_BITS-1:0] make_blk(input logic [ADDR_W-1:0] a,
                                                     input logic [ADDR_W-1:0] nxt,
                                                     input logic              eop);
    logic [15:0] tag;
    tag = {a, 4'h5};
    return {{31{tag}}, nxt, eop, 3'b101};
  endfunction

  task automatic push_expected(input logic [ADDR_W-1:0] start_a);
    logic [ADDR_W-1:0] a;
    a = start_a;
    for (int k = 0; k < 64; k++) begin
      exp_addr_q.push_back(a);
      exp_q.push_back(make_blk(a, next_m[a], eop_m[a]));
      exp_end_q.push_back(eop_m[a]);
      if (eop_m[a]) break;
      a = next_m[a];
    end
  endtask

  // Monitor: scores every strobe and delivery, and data_o hold between them.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (mem_re_o) begin
        total++;
        if (!re_i) begin
          bad++;
          $display("FAIL read_while_stalled: got mem_re_o=1 addr=%0d want no read", mem_raddr_o);
        end else if (exp_addr_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read: got addr=%0d want none", mem_raddr_o);
        end else begin
          logic [ADDR_W-1:0] ea;
          ea = exp_addr_q.pop_front();
          if (mem_raddr_o !== ea) begin
            bad++;
            $display("FAIL read_addr: got %0d want %0d", mem_raddr_o, ea);
          end
        end
      end
      if (data_valid_o) begin
        dv_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_data: got %0h want none", data_o[15:0]);
        end else begin
          logic [BLOCK_BITS-1:0] eb;
          logic                  ee;
          eb = exp_q.pop_front();
          ee = exp_end_q.pop_front();
          last_exp = eb;
          if (data_o !== eb || data_end_o !== ee) begin
            bad++;
            $display("FAIL data: got %0h end=%0b want %0h end=%0b", data_o, data_end_o, eb, ee);
          end
        end
      end else begin
        check("data_hold", data_o, last_exp);
        check("end_without_valid", {511'd0, data_end_o}, '0);
      end
    end
  end

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [ADDR_W-1:0] start_addr;
    int gap_after;
    int gap_len;
    int restart_after;
    int exp_n;
    int exp_last_cyc;
  } vec_t;

  vec_t vecs [7];

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},   {510'd0, state_o}, {510'd0, IDLE});
    check({tag, "_mem_re"},  {511'd0, mem_re_o}, '0);
    check({tag, "_raddr"},   {500'd0, mem_raddr_o}, '0);
    check({tag, "_data"},    data_o, '0);
    check({tag, "_valid"},   {511'd0, data_valid_o}, '0);
    check({tag, "_end"},     {511'd0, data_end_o}, '0);
  endtask

  // Runs one walk: start pulse, optional re_i gap or spurious start, timing checks.
  task automatic run_vec(input vec_t v);
    int cyc;
    int n_seen;
    bit done;
    push_expected(v.start_addr);
    dv_cnt = 0;
    cyc = 0;
    n_seen = 0;
    done = 1'b0;
    start_addr_i = v.start_addr;
    start = 1'b1;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (data_valid_o) begin
        n_seen++;
        if (n_seen == 1) check("first_latency", cyc, 3);
        if (data_end_o) begin
          done = 1'b1;
          check("last_cycle", cyc, v.exp_last_cyc);
        end else if (n_seen == v.gap_after) begin
          re_i = 1'b0;
          repeat (v.gap_len) begin
            @(posedge clk); #1;
            cyc++;
          end
          check("stall_state", {510'd0, state_o}, {510'd0, ISSUE});
          re_i = 1'b1;
        end else if (n_seen == v.restart_after) begin
          start_addr_i = '0;
          start = 1'b1;
        end
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL walk_timeout: got no data_end_o in %0d cycles want end", cyc);
    end
    repeat (3) @(posedge clk);
    #1;
    check("block_count", dv_cnt, v.exp_n);
    check("addr_q_empty", exp_addr_q.size(), 0);
    check("data_q_empty", exp_q.size(), 0);
    check("end_state", {510'd0, state_o}, {510'd0, IDLE});
    exp_addr_q.delete();
    exp_q.delete();
    exp_end_q.delete();
  endtask

  // ---------------- main ----------------
  initial begin
    int n_seen;
    rst = 1'b1;
    re_i = 1'b1;
    start = 1'b0;
    start_addr_i = '0;
    rvalid_force = 1'b0;
    we_tb = 1'b0;
    waddr_tb = '0;
    wdata_tb = '0;
    last_exp = '0;
    chain = '{12'd37, 12'd905, 12'd128, 12'd2047, 12'd319,
              12'd4093, 12'd777, 12'd2560, 12'd1234, 12'd3001};
    for (int i = 0; i < MEM_DEPTH; i++) begin
      next_m[i] = '0;
      eop_m[i]  = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      next_m[chain[i]] = (i == 9) ? 12'd55 : chain[i+1];
      eop_m[chain[i]]  = (i == 9);
    end
    next_m[4095] = 12'd0;
    eop_m[4095]  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");

    // load the memory image while the reader is held in reset
    for (int i = 0; i < 10; i++) begin
      we_tb = 1'b1;
      waddr_tb = chain[i];
      wdata_tb = make_blk(chain[i], next_m[chain[i]], eop_m[chain[i]]);
      @(posedge clk); #1;
    end
    waddr_tb = 12'd4095;
    wdata_tb = make_blk(12'd4095, next_m[4095], eop_m[4095]);
    @(posedge clk); #1;
    we_tb = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    //        start   gap_after gap_len restart n   last_cyc
    vecs[0] = '{12'd37,   -1, 0, -1, 10, 21};
    vecs[1] = '{12'd4095, -1, 0, -1,  1,  3};
    vecs[2] = '{12'd37,    3, 5, -1, 10, 26};
    vecs[3] = '{12'd37,   -1, 0,  2, 10, 21};
    vecs[4] = '{12'd2047, -1, 0, -1,  7, 15};
    vecs[5] = '{12'd1234, -1, 0, -1,  2,  5};
    vecs[6] = '{12'd3001, -1, 0, -1,  1,  3};
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    // reset after the 4th block of a walk from 37
    push_expected(12'd37);
    n_seen = 0;
    start_addr_i = 12'd37;
    start = 1'b1;
    for (int c = 0; c < 100 && n_seen < 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (data_valid_o) n_seen++;
    end
    check("pre_reset_blocks", n_seen, 4);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    check("rst_addr_left", exp_addr_q.size(), 5);
    check("rst_data_left", exp_q.size(), 6);
    exp_addr_q.delete();
    exp_q.delete();
    exp_end_q.delete();
    last_exp = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // stray rvalid in IDLE must not deliver anything
    rvalid_force = 1'b1;
    @(posedge clk); #1;
    rvalid_force = 1'b0;
    check("late_rvalid_valid", {511'd0, data_valid_o}, '0);
    check("late_rvalid_data", data_o, '0);
    check("late_rvalid_state", {510'd0, state_o}, {510'd0, IDLE});
    @(posedge clk); #1;

    run_vec(vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memory_read_ctrl.md
MEMORY_READ_CTRL -- requirements
Module: memory_read_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 re_i  in  1  read enable; 0 pauses issue of new memory reads.
REQ-004 start  in  1  one-cycle pulse; begins a chain walk at start_addr_i.
REQ-005 start_addr_i  in  ADDR_W  block index of the first block in the chain.
REQ-006 mem_re_o  out  1  memory read strobe, one cycle per block.
REQ-007 mem_raddr_o  out  ADDR_W  memory read block index.
REQ-008 mem_rvalid_i  in  1  mem_rdata_i is valid this cycle.
REQ-009 mem_rdata_i  in  BLOCK_BITS  block returned by memory.
REQ-010 data_o  out  BLOCK_BITS  registered copy of the returned block.
REQ-011 data_valid_o  out  1  one-cycle pulse per delivered block.
REQ-012 data_end_o  out  1  high together with data_valid_o on the block whose footer eop=1.

Function
REQ-013 Footer SHALL occupy block bits [15:0]: next_idx=[15:4], eop=[3], rsvd=[2:0]; rsvd SHALL be ignored.
REQ-014 FSM states SHALL be IDLE, ISSUE and WAIT.
REQ-015 IDLE: start=1 SHALL latch start_addr_i into cur_addr and move to ISSUE; start in any other state SHALL be ignored.
REQ-016 ISSUE with re_i=1: mem_re_o=1 and mem_raddr_o=cur_addr (combinational) for exactly one cycle, then WAIT.
REQ-017 ISSUE with re_i=0: mem_re_o=0 and the FSM SHALL remain in ISSUE (stall).
REQ-018 mem_raddr_o SHALL always equal cur_addr, whatever the state.
REQ-019 WAIT with mem_rvalid_i=1: the next edge SHALL load data_o<=mem_rdata_i, data_valid_o<=1, data_end_o<=eop.
REQ-020 On that same edge the FSM SHALL go to IDLE if eop=1; otherwise it SHALL set cur_addr<=next_idx and go to ISSUE.
REQ-021 WAIT without mem_rvalid_i SHALL hold; there is no timeout.
REQ-022 data_valid_o and data_end_o SHALL be single-cycle pulses; data_o SHALL hold its last value until the next delivery.
REQ-023 Memory latency SHALL be exactly one cycle: mem_rvalid_i rises the cycle after mem_re_o.
REQ-024 Steady-state throughput SHALL be one block per 2 cycles; first data_valid_o SHALL occur 3 cycles after the start edge.
REQ-025 next_idx SHALL use all ADDR_W bits with no wrap logic; indices 0 and 4095 are legal.
REQ-026 At most one read SHALL be outstanding at any time.

Reset
REQ-027 rst=1 SHALL immediately force: state=IDLE, cur_addr=0, mem_re_o=0, data_o=0, data_valid_o=0, data_end_o=0.
REQ-028 Reset mid-chain SHALL abandon the walk; a late mem_rvalid_i arriving in IDLE SHALL be ignored.

Structure
REQ-029 Package mem_pkg SHALL define ADDR_W=12, BLOCK_BITS=512 and packed footer_t {next_idx[11:0], eop, rsvd[2:0]} (16 bits).
REQ-030 Companion module sram (ports clk, we, re, addr, wdata, rdata) SHALL hold 2^ADDR_W blocks of BLOCK_BITS, with synchronous write and rdata registered one cycle after re; memory_read_ctrl SHALL NOT instantiate it.
REQ-031 memory_read_ctrl SHALL contain no sub-modules.

Verification
REQ-032 Program chain 37,905,128,2047,319,4093,777,2560,1234,3001 (last block eop=1); start at 37 with re_i=1 -> exactly 10 data_valid_o pulses with mem_raddr_o in chain order, each footer next_idx = following link, data_end_o only on block at 3001, FSM back in IDLE.
REQ-033 Single block at 4095 with eop=1 -> one data_valid_o with data_end_o=1 and no further mem_re_o.
REQ-034 Drop re_i for 5 cycles after the 3rd block -> no mem_re_o during the gap; walk resumes and all 10 blocks still arrive in order.
REQ-035 Pulse start again mid-chain with start_addr_i=0 -> ignored; the walk is unchanged.
REQ-036 Assert rst after the 4th block -> all outputs 0 at once; a following start at 2047 walks 7 blocks to the end.
